// File: rtl/switch_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : switch_scheduler_if
//  Description : Core-side handshake bundle between the cores and the
//                inter-core Switch rendezvous controller. The master side is
//                the core array; the slave side is the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface switch_scheduler_if #(
    parameter int CORE_SIZE      = 3,
    parameter int CORE_ADDR_SIZE = $clog2(CORE_SIZE)
);
    // Send side: one outgoing message slot per core
    logic [CORE_SIZE-1:0]                     send_ready;
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] send_core_idx;
    logic [CORE_SIZE-1:0]                     send_idle;
    logic [CORE_SIZE-1:0]                     send_ok;

    // Receive side: one receive request slot per core
    logic [CORE_SIZE-1:0]                     recv_request;
    logic [CORE_SIZE-1:0]                     recv_any;
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] recv_core_idx;
    logic [CORE_SIZE-1:0]                     recv_ready;
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] recv_src;

    // Crossbar control toward the Switch datapath
    logic [CORE_SIZE-1:0]                     xbar_valid;
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] xbar_src_sel;

    modport master (
        output send_ready, send_core_idx, recv_request, recv_any, recv_core_idx,
        input  send_idle, send_ok, recv_ready, recv_src, xbar_valid, xbar_src_sel
    );

    modport slave (
        input  send_ready, send_core_idx, recv_request, recv_any, recv_core_idx,
        output send_idle, send_ok, recv_ready, recv_src, xbar_valid, xbar_src_sel
    );
endinterface
`default_nettype wire

// File: rtl/switch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : switch_scheduler
//  Description : Rendezvous controller for the inter-core Switch. Holds one
//                posted send and one posted receive per core, pairs each
//                waiting receive with a compatible pending send (round-robin
//                over sources for any-source receives) and issues one-cycle
//                delivery pulses plus the per-output crossbar select.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_scheduler #(
    parameter int CORE_SIZE      = 3,
    parameter int CORE_ADDR_SIZE = $clog2(CORE_SIZE)
) (
    input  wire logic          clock,
    input  wire logic          reset,
    switch_scheduler_if.slave  bus
);

    localparam int                        c_core_size = CORE_SIZE;
    localparam logic [CORE_ADDR_SIZE-1:0] c_rr_init   = CORE_ADDR_SIZE'(CORE_SIZE - 1);

    typedef enum logic [0:0] {
        SEND_IDLE    = 1'b0,
        SEND_PENDING = 1'b1
    } send_state_t;

    typedef enum logic [0:0] {
        RECV_IDLE = 1'b0,
        RECV_WAIT = 1'b1
    } recv_state_t;

    // Slot state
    send_state_t                              r_send_state [CORE_SIZE];
    send_state_t                              w_send_state_nxt [CORE_SIZE];
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] r_send_dest;
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] w_send_dest_nxt;

    recv_state_t                              r_recv_state [CORE_SIZE];
    recv_state_t                              w_recv_state_nxt [CORE_SIZE];
    logic [CORE_SIZE-1:0]                     r_recv_any;
    logic [CORE_SIZE-1:0]                     w_recv_any_nxt;
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] r_recv_want;
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] w_recv_want_nxt;

    // Round-robin pointer per destination: last source served on an any-receive
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] r_rr_ptr;
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] w_rr_ptr_nxt;

    // Match results for the current cycle
    logic [CORE_SIZE-1:0]                     w_match;
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] w_match_src;
    logic [CORE_SIZE-1:0]                     w_send_done;

    // Registered pulses and held selects
    logic [CORE_SIZE-1:0]                     r_send_ok;
    logic [CORE_SIZE-1:0]                     r_recv_ready;
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] r_recv_src;
    logic [CORE_SIZE-1:0]                     r_xbar_valid;
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] r_xbar_src_sel;
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] w_src_hold_nxt;

    // Pair every waiting receive with a pending send aimed at it
    always_comb begin
        int                        v_s;
        logic [CORE_ADDR_SIZE-1:0] v_idx;
        v_s         = 0;
        v_idx       = '0;
        w_match     = '0;
        w_match_src = '0;
        for (int j = 0; j < CORE_SIZE; j++) begin
            if (r_recv_state[j] == RECV_WAIT) begin
                if (r_recv_any[j]) begin
                    // Scan sources starting just after the last one served
                    for (int k = 1; k <= CORE_SIZE; k++) begin
                        v_s = int'(r_rr_ptr[j]) + k;
                        if (v_s >= c_core_size) begin
                            v_s = v_s - c_core_size;
                        end
                        v_idx = CORE_ADDR_SIZE'(v_s);
                        if (!w_match[j] &&
                            r_send_state[v_idx] == SEND_PENDING &&
                            r_send_dest[v_idx] == CORE_ADDR_SIZE'(j)) begin
                            w_match[j]     = 1'b1;
                            w_match_src[j] = v_idx;
                        end
                    end
                end else begin
                    v_idx = r_recv_want[j];
                    if (r_send_state[v_idx] == SEND_PENDING &&
                        r_send_dest[v_idx] == CORE_ADDR_SIZE'(j)) begin
                        w_match[j]     = 1'b1;
                        w_match_src[j] = v_idx;
                    end
                end
            end
        end
    end

    // A source is delivered when any destination picked it (at most one can)
    always_comb begin
        w_send_done = '0;
        for (int s = 0; s < CORE_SIZE; s++) begin
            for (int j = 0; j < CORE_SIZE; j++) begin
                if (w_match[j] && w_match_src[j] == CORE_ADDR_SIZE'(s)) begin
                    w_send_done[s] = 1'b1;
                end
            end
        end
    end

    // Next-state for send and receive slots, round-robin pointers and held selects
    always_comb begin
        w_send_dest_nxt = r_send_dest;
        w_recv_any_nxt  = r_recv_any;
        w_recv_want_nxt = r_recv_want;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_src_hold_nxt  = r_xbar_src_sel;
        for (int i = 0; i < CORE_SIZE; i++) begin
            w_send_state_nxt[i] = r_send_state[i];
            w_recv_state_nxt[i] = r_recv_state[i];
        end

        for (int i = 0; i < CORE_SIZE; i++) begin
            case (r_send_state[i])
                SEND_IDLE: begin
                    // Out-of-range destinations are dropped silently
                    if (bus.send_ready[i] && int'(bus.send_core_idx[i]) < c_core_size) begin
                        w_send_state_nxt[i] = SEND_PENDING;
                        w_send_dest_nxt[i]  = bus.send_core_idx[i];
                    end
                end
                SEND_PENDING: begin
                    // New send_ready is ignored until this message is delivered
                    if (w_send_done[i]) begin
                        w_send_state_nxt[i] = SEND_IDLE;
                    end
                end
                default: w_send_state_nxt[i] = SEND_IDLE;
            endcase
        end

        for (int j = 0; j < CORE_SIZE; j++) begin
            case (r_recv_state[j])
                RECV_IDLE: begin
                    if (bus.recv_request[j] &&
                        (bus.recv_any[j] || int'(bus.recv_core_idx[j]) < c_core_size)) begin
                        w_recv_state_nxt[j] = RECV_WAIT;
                        w_recv_any_nxt[j]   = bus.recv_any[j];
                        w_recv_want_nxt[j]  = bus.recv_core_idx[j];
                    end
                end
                RECV_WAIT: begin
                    if (w_match[j]) begin
                        w_recv_state_nxt[j] = RECV_IDLE;
                        w_src_hold_nxt[j]   = w_match_src[j];
                        if (r_recv_any[j]) begin
                            w_rr_ptr_nxt[j] = w_match_src[j];
                        end
                    end
                end
                default: w_recv_state_nxt[j] = RECV_IDLE;
            endcase
        end
    end

    // Slot state and round-robin registers
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CORE_SIZE; i++) begin
                r_send_state[i] <= SEND_IDLE;
                r_recv_state[i] <= RECV_IDLE;
                r_rr_ptr[i]     <= c_rr_init;
            end
            r_send_dest <= '0;
            r_recv_any  <= '0;
            r_recv_want <= '0;
        end else begin
            for (int i = 0; i < CORE_SIZE; i++) begin
                r_send_state[i] <= w_send_state_nxt[i];
                r_recv_state[i] <= w_recv_state_nxt[i];
            end
            r_send_dest <= w_send_dest_nxt;
            r_recv_any  <= w_recv_any_nxt;
            r_recv_want <= w_recv_want_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
        end
    end

    // Delivery pulses last one cycle; selects keep their last value
    always_ff @(posedge clock) begin
        if (reset) begin
            r_send_ok      <= '0;
            r_recv_ready   <= '0;
            r_xbar_valid   <= '0;
            r_recv_src     <= '0;
            r_xbar_src_sel <= '0;
        end else begin
            r_send_ok      <= w_send_done;
            r_recv_ready   <= w_match;
            r_xbar_valid   <= w_match;
            r_recv_src     <= w_src_hold_nxt;
            r_xbar_src_sel <= w_src_hold_nxt;
        end
    end

    // Free-slot flag decoded from the registered send state
    always_comb begin
        for (int i = 0; i < CORE_SIZE; i++) begin
            bus.send_idle[i] = (r_send_state[i] == SEND_IDLE);
        end
    end

    assign bus.send_ok      = r_send_ok;
    assign bus.recv_ready   = r_recv_ready;
    assign bus.recv_src     = r_recv_src;
    assign bus.xbar_valid   = r_xbar_valid;
    assign bus.xbar_src_sel = r_xbar_src_sel;

endmodule
`default_nettype wire

// File: tb/tb_switch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_scheduler
//  Description : Self-checking bench for switch_scheduler. Directed scenarios
//                followed by random traffic, every cycle compared against a
//                message-level reference model of the rendezvous rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_scheduler;

    localparam int N = 3;
    localparam int A = 2;

    logic clock;
    logic reset;

    switch_scheduler_if #(.CORE_SIZE(N), .CORE_ADDR_SIZE(A)) bus ();

    switch_scheduler #(.CORE_SIZE(N), .CORE_ADDR_SIZE(A)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: destination of each posted message (-1 = none),
    // outstanding receives, and the last source served per destination
    int m_dest  [N];
    bit m_rwait [N];
    bit m_rany  [N];
    int m_rsrc  [N];
    int m_rr    [N];

    logic [N-1:0]        e_idle, e_ok, e_rdy, e_xv;
    logic [N-1:0][A-1:0] e_src, e_sel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        int  got [N];
        bit  s_free [N];
        bit  r_free [N];
        int  s;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_dest[i]  = -1;
                m_rwait[i] = 1'b0;
                m_rany[i]  = 1'b0;
                m_rsrc[i]  = 0;
                m_rr[i]    = N - 1;
            end
            e_ok  = '0;
            e_rdy = '0;
            e_xv  = '0;
            e_src = '0;
            e_sel = '0;
        end else begin
            for (int j = 0; j < N; j++) begin
                got[j]    = -1;
                s_free[j] = (m_dest[j] < 0);
                r_free[j] = !m_rwait[j];
            end
            for (int j = 0; j < N; j++) begin
                if (m_rwait[j]) begin
                    if (m_rany[j]) begin
                        for (int k = 1; k <= N; k++) begin
                            s = (m_rr[j] + k) % N;
                            if (got[j] < 0 && m_dest[s] == j) got[j] = s;
                        end
                    end else if (m_dest[m_rsrc[j]] == j) begin
                        got[j] = m_rsrc[j];
                    end
                end
            end
            e_ok  = '0;
            e_rdy = '0;
            e_xv  = '0;
            for (int j = 0; j < N; j++) begin
                if (got[j] >= 0) begin
                    e_rdy[j]       = 1'b1;
                    e_xv[j]        = 1'b1;
                    e_src[j]       = A'(got[j]);
                    e_sel[j]       = A'(got[j]);
                    e_ok[got[j]]   = 1'b1;
                    m_dest[got[j]] = -1;
                    m_rwait[j]     = 1'b0;
                    if (m_rany[j]) m_rr[j] = got[j];
                end
            end
            for (int i = 0; i < N; i++) begin
                if (s_free[i] && bus.send_ready[i] && int'(bus.send_core_idx[i]) < N)
                    m_dest[i] = int'(bus.send_core_idx[i]);
                if (r_free[i] && bus.recv_request[i] &&
                    (bus.recv_any[i] || int'(bus.recv_core_idx[i]) < N)) begin
                    m_rwait[i] = 1'b1;
                    m_rany[i]  = bus.recv_any[i];
                    m_rsrc[i]  = int'(bus.recv_core_idx[i]);
                end
            end
        end
        for (int i = 0; i < N; i++) e_idle[i] = (m_dest[i] < 0);
    endtask

    task automatic clear_inputs();
        reset             = 1'b0;
        bus.send_ready    = '0;
        bus.send_core_idx = '0;
        bus.recv_request  = '0;
        bus.recv_any      = '0;
        bus.recv_core_idx = '0;
    endtask

    // One clock: model, edge, compare every output, then drop the inputs
    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        check("send_idle",    32'(bus.send_idle),    32'(e_idle));
        check("send_ok",      32'(bus.send_ok),      32'(e_ok));
        check("recv_ready",   32'(bus.recv_ready),   32'(e_rdy));
        check("recv_src",     32'(bus.recv_src),     32'(e_src));
        check("xbar_valid",   32'(bus.xbar_valid),   32'(e_xv));
        check("xbar_src_sel", 32'(bus.xbar_src_sel), 32'(e_sel));
        clear_inputs();
    endtask

    task automatic post_send(input int i, input int dest);
        bus.send_ready[i]    = 1'b1;
        bus.send_core_idx[i] = A'(dest);
    endtask

    task automatic post_recv(input int j, input bit any, input int src);
        bus.recv_request[j]  = 1'b1;
        bus.recv_any[j]      = any;
        bus.recv_core_idx[j] = A'(src);
    endtask

    task automatic ticks(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    initial begin
        clear_inputs();
        for (int i = 0; i < N; i++) begin
            m_dest[i] = -1; m_rwait[i] = 1'b0; m_rany[i] = 1'b0;
            m_rsrc[i] = 0;  m_rr[i]    = N - 1;
        end

        // Reset state
        reset = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("rst_send_idle",  32'(bus.send_idle),  32'h7);
        check("rst_recv_ready", 32'(bus.recv_ready), 32'h0);
        check("rst_xbar_sel",   32'(bus.xbar_src_sel), 32'h0);

        // Deferred receive: send at cycle 0, receive at cycle 4, pulse at cycle 6
        post_send(2, 1);
        tick();
        check("t1_idle2_c1", 32'(bus.send_idle[2]), 32'h0);
        ticks(3);
        check("t1_idle2_c4", 32'(bus.send_idle[2]), 32'h0);
        post_recv(1, 1'b0, 2);
        tick();
        check("t1_no_pulse_c5", 32'(bus.recv_ready), 32'h0);
        tick();
        check("t1_recv_ready", 32'(bus.recv_ready), 32'h2);
        check("t1_recv_src",   32'(bus.recv_src[1]), 32'h2);
        check("t1_xbar_sel",   32'(bus.xbar_src_sel[1]), 32'h2);
        check("t1_send_ok",    32'(bus.send_ok), 32'h4);
        check("t1_idle2_c6",   32'(bus.send_idle[2]), 32'h1);
        tick();
        check("t1_pulse_gone", 32'(bus.xbar_valid), 32'h0);
        check("t1_src_held",   32'(bus.recv_src[1]), 32'h2);

        // Simultaneous self-send and receive; re-post in the pulse cycle
        post_send(0, 0);
        post_recv(0, 1'b0, 0);
        tick();
        tick();
        check("t2_send_ok",  32'(bus.send_ok[0]), 32'h1);
        check("t2_recv_rdy", 32'(bus.recv_ready[0]), 32'h1);
        post_send(0, 1);
        tick();
        check("t2_repost_idle", 32'(bus.send_idle[0]), 32'h0);

        // Round-robin: sources 0 and 2 pending to dest 1
        post_send(2, 1);
        tick();
        post_recv(1, 1'b1, 0);
        ticks(2);
        check("t3_first_src", 32'(bus.recv_src[1]), 32'h0);
        post_recv(1, 1'b1, 0);
        ticks(2);
        check("t3_second_src", 32'(bus.recv_src[1]), 32'h2);
        post_send(0, 1); post_send(1, 1); post_send(2, 1);
        tick();
        for (int n = 0; n < 3; n++) begin
            post_recv(1, 1'b1, 0);
            ticks(2);
            check("t3_order", 32'(bus.recv_src[1]), 32'(n));
        end

        // Mismatch: source 0 to dest 1, but dest 1 waits on source 2
        post_send(0, 1);
        tick();
        post_recv(1, 1'b0, 2);
        tick();
        ticks(10);
        check("t4_no_pulse", 32'(bus.recv_ready), 32'h0);
        post_send(2, 1);
        ticks(2);
        check("t4_delivered", 32'(bus.recv_src[1]), 32'h2);
        check("t4_rdy",       32'(bus.recv_ready[1]), 32'h1);
        check("t4_src0_pend", 32'(bus.send_idle[0]), 32'h0);

        // Drops and ignored re-posts
        post_send(1, 3);
        tick();
        check("t5_drop_idle", 32'(bus.send_idle[1]), 32'h1);
        post_send(1, 2);
        tick();
        post_send(1, 0);
        tick();
        post_recv(2, 1'b1, 0);
        ticks(2);
        check("t5_kept_dest", 32'(bus.recv_ready[2]), 32'h1);
        check("t5_kept_src",  32'(bus.recv_src[2]), 32'h1);

        // Reset mid-operation clears slots and round-robin pointers
        post_send(1, 2);
        post_recv(2, 1'b0, 0);
        tick();
        reset = 1'b1;
        tick();
        check("t6_idle", 32'(bus.send_idle), 32'h7);
        tick();
        check("t6_no_pulse", 32'(bus.recv_ready | bus.send_ok), 32'h0);
        post_send(1, 2); post_send(2, 2);
        tick();
        post_recv(2, 1'b1, 0);
        ticks(2);
        check("t6_rr_from_0", 32'(bus.recv_src[2]), 32'h1);
        ticks(2);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) post_send(i, int'($urandom_range(0, 3)));
                if ($urandom_range(0, 3) == 0)
                    post_recv(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
